// File: rtl/vec_beat_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_beat_sequencer_pkg
// Description : Shared definitions for the vector beat sequencer. Provides the
//               SEW encoding constants, the sequencer state enum and a helper
//               that returns log2(elements per beat) for a given SEW code.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_beat_sequencer_pkg;

    // Element width encodings carried on req_sew
    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // log2(elements per beat) = log2(bytes per beat) - sew.
    // Clamped at zero so an element wider than the datapath still yields one
    // element per beat instead of a negative shift.
    function automatic int unsigned epw_log2(input int unsigned dw_b_bits,
                                             input int unsigned sew);
        return (sew > dw_b_bits) ? 0 : (dw_b_bits - sew);
    endfunction

endpackage : vec_beat_sequencer_pkg
`default_nettype wire

// File: rtl/vec_beat_sequencer_generate_be.sv
`default_nettype none
// ============================================================================
// Module      : vec_beat_sequencer_generate_be
// Description : Combinational byte-enable generator for one beat. Byte i is
//               enabled when the element it belongs to lies below avl.
// Ports       : sew_i  - element width code
//               avl_i  - active vector length, elements
//               off_i  - data-word offset of the beat
//               be_o   - byte enable, tail bytes cleared
// Revision    : 1.0 - initial release
// ============================================================================
module vec_beat_sequencer_generate_be
    import vec_beat_sequencer_pkg::*;
#(
    parameter int AVL_WIDTH = 12,
    parameter int DW_B      = 8,
    parameter int DW_B_BITS = 3,
    parameter int SEW_WIDTH = 2
) (
    input  logic [SEW_WIDTH-1:0] sew_i,
    input  logic [AVL_WIDTH-1:0] avl_i,
    input  logic [AVL_WIDTH-1:0] off_i,
    output logic [DW_B-1:0]      be_o
);

    // Wide enough for off * elements_per_beat plus the in-beat element index
    localparam int IDX_W = AVL_WIDTH + DW_B_BITS + 1;

    logic [IDX_W-1:0] w_base;

    // First element index carried by this beat
    always_comb begin
        w_base = IDX_W'(off_i) << epw_log2(DW_B_BITS, 32'(sew_i));
    end

    always_comb begin
        be_o = '0;
        for (int i = 0; i < DW_B; i++) begin
            be_o[i] = (w_base + IDX_W'(i >> sew_i)) < IDX_W'(avl_i);
        end
    end

endmodule : vec_beat_sequencer_generate_be
`default_nettype wire

// File: rtl/vec_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vec_beat_sequencer
// Description : Splits one vector operation (sew, avl) into DATA_WIDTH-wide
//               beats. Each beat carries its word offset, a tail byte-enable
//               and a last flag. Valid/ready handshake on both sides.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               req_valid/req_ready/req_sew/req_avl - operation request
//               flush                            - abort current operation
//               beat_valid/beat_ready/beat_off/beat_be/beat_last - beat stream
//               done                             - operation finished pulse
//               err                              - illegal request pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vec_beat_sequencer
    import vec_beat_sequencer_pkg::*;
#(
    parameter int VLEN          = 16384,
    parameter int AVL_WIDTH     = $clog2(VLEN/8) + 1,
    parameter int DATA_WIDTH    = 64,
    parameter int DW_B          = DATA_WIDTH / 8,
    parameter int DW_B_BITS     = $clog2(DW_B),
    parameter int SEW_WIDTH     = 2,
    parameter int ENABLE_64_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SEW_WIDTH-1:0] req_sew,
    input  logic [AVL_WIDTH-1:0] req_avl,
    input  logic                 flush,
    output logic                 beat_valid,
    input  logic                 beat_ready,
    output logic [AVL_WIDTH-1:0] beat_off,
    output logic [DW_B-1:0]      beat_be,
    output logic                 beat_last,
    output logic                 done,
    output logic                 err
);

    state_e               state_q,  state_d;
    logic [SEW_WIDTH-1:0] sew_q,    sew_d;
    logic [AVL_WIDTH-1:0] avl_q,    avl_d;
    logic [AVL_WIDTH-1:0] nbeats_q, nbeats_d;
    logic [AVL_WIDTH-1:0] off_q,    off_d;
    logic [DW_B-1:0]      be_q,     be_d;
    logic                 valid_q,  valid_d;
    logic                 last_q,   last_d;
    logic                 done_q,   done_d;
    logic                 err_q,    err_d;

    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_be_load;
    logic                 w_be_clr;
    logic [AVL_WIDTH:0]   w_req_nbeats;
    logic [SEW_WIDTH-1:0] w_gen_sew;
    logic [AVL_WIDTH-1:0] w_gen_avl;
    logic [DW_B-1:0]      w_be;

    assign w_accept  = req_valid && (state_q == IDLE);
    assign w_illegal = (ENABLE_64_BIT == 0) && (req_sew == SEW_WIDTH'(SEW_64));

    // Ceiling divide of avl by elements-per-beat, one extra bit for the carry
    always_comb begin
        int unsigned sh;
        sh           = epw_log2(DW_B_BITS, 32'(req_sew));
        w_req_nbeats = (({1'b0, req_avl} + ((AVL_WIDTH+1)'(1) << sh)) - (AVL_WIDTH+1)'(1)) >> sh;
    end

    // Beat 0 must be ready the cycle after accept, before sew/avl are latched,
    // so the generator sees the incoming request on the accept cycle.
    assign w_gen_sew = w_accept ? req_sew : sew_q;
    assign w_gen_avl = w_accept ? req_avl : avl_q;

    vec_beat_sequencer_generate_be #(
        .AVL_WIDTH (AVL_WIDTH),
        .DW_B      (DW_B),
        .DW_B_BITS (DW_B_BITS),
        .SEW_WIDTH (SEW_WIDTH)
    ) u_generate_be (
        .sew_i (w_gen_sew),
        .avl_i (w_gen_avl),
        .off_i (off_d),
        .be_o  (w_be)
    );

    // Next-state and beat bookkeeping
    always_comb begin
        state_d   = state_q;
        sew_d     = sew_q;
        avl_d     = avl_q;
        nbeats_d  = nbeats_q;
        off_d     = off_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        w_be_load = 1'b0;
        w_be_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    sew_d    = req_sew;
                    avl_d    = req_avl;
                    nbeats_d = w_req_nbeats[AVL_WIDTH-1:0];
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else if (w_req_nbeats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        off_d     = '0;
                        valid_d   = 1'b1;
                        last_d    = (w_req_nbeats == (AVL_WIDTH+1)'(1));
                        w_be_load = 1'b1;
                    end
                end
            end
            RUN: begin
                // Flush takes priority over a same-cycle handshake
                if (flush || (valid_q && beat_ready && last_q)) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                    off_d    = '0;
                    done_d   = 1'b1;
                    w_be_clr = 1'b1;
                end else if (valid_q && beat_ready) begin
                    off_d     = off_q + AVL_WIDTH'(1);
                    last_d    = ((off_q + AVL_WIDTH'(1)) == (nbeats_q - AVL_WIDTH'(1)));
                    w_be_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        be_d = be_q;
        if (w_be_clr) begin
            be_d = '0;
        end else if (w_be_load) begin
            be_d = w_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sew_q    <= '0;
            avl_q    <= '0;
            nbeats_q <= '0;
            off_q    <= '0;
            be_q     <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sew_q    <= sew_d;
            avl_q    <= avl_d;
            nbeats_q <= nbeats_d;
            off_q    <= off_d;
            be_q     <= be_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign beat_valid = valid_q;
    assign beat_off   = off_q;
    assign beat_be    = be_q;
    assign beat_last  = last_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule : vec_beat_sequencer
`default_nettype wire

// File: tb/tb_vec_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_beat_sequencer
// Description : Directed self-checking bench for vec_beat_sequencer with a
//               64-bit datapath. A second instance has 64-bit elements
//               disabled to exercise the illegal-request path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_beat_sequencer;

    localparam int AW = 12;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_valid2;
    logic [1:0]    req_sew;
    logic [AW-1:0] req_avl;
    logic          flush;
    logic          beat_ready;

    logic          req_ready,  req_ready2;
    logic          beat_valid, beat_valid2;
    logic [AW-1:0] beat_off,   beat_off2;
    logic [7:0]    beat_be,    beat_be2;
    logic          beat_last,  beat_last2;
    logic          done,       done2;
    logic          err,        err2;

    int checks = 0;
    int errors = 0;

    vec_beat_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sew    (req_sew),
        .req_avl    (req_avl),
        .flush      (flush),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_off   (beat_off),
        .beat_be    (beat_be),
        .beat_last  (beat_last),
        .done       (done),
        .err        (err)
    );

    vec_beat_sequencer #(.ENABLE_64_BIT(0)) dut_no64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid2),
        .req_ready  (req_ready2),
        .req_sew    (req_sew),
        .req_avl    (req_avl),
        .flush      (flush),
        .beat_valid (beat_valid2),
        .beat_ready (beat_ready),
        .beat_off   (beat_off2),
        .beat_be    (beat_be2),
        .beat_last  (beat_last2),
        .done       (done2),
        .err        (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic [AW-1:0] off,
                            input logic [7:0] be, input logic last);
        chk({tag, "_valid"}, 32'(beat_valid), 32'(v));
        chk({tag, "_off"},   32'(beat_off),   32'(off));
        chk({tag, "_be"},    32'(beat_be),    32'(be));
        chk({tag, "_last"},  32'(beat_last),  32'(last));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
        req_sew    = 2'd0;
        req_avl    = '0;
        flush      = 1'b0;
        beat_ready = 1'b0;
        #2;
        // Reset state
        chk_beat("rst", 1'b0, 12'd0, 8'h00, 1'b0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // sew=8 avl=10: two beats, tail 0x03
        req_valid = 1'b1; req_sew = 2'd0; req_avl = 12'd10;
        tick();
        req_valid = 1'b0; beat_ready = 1'b1;
        chk_beat("a_b0", 1'b1, 12'd0, 8'hFF, 1'b0);
        chk("a_ready_run", 32'(req_ready), 32'd0);
        tick();
        chk_beat("a_b1", 1'b1, 12'd1, 8'h03, 1'b1);
        chk("a_nodone", 32'(done), 32'd0);
        tick();
        chk("a_valid_end", 32'(beat_valid), 32'd0);
        chk("a_done",      32'(done),       32'd1);
        chk("a_ready_end", 32'(req_ready),  32'd1);
        tick();
        chk("a_done_pulse", 32'(done), 32'd0);

        // sew=32 avl=3: 0xFF then 0x0F
        req_valid = 1'b1; req_sew = 2'd2; req_avl = 12'd3;
        tick();
        req_valid = 1'b0;
        chk_beat("b_b0", 1'b1, 12'd0, 8'hFF, 1'b0);
        tick();
        chk_beat("b_b1", 1'b1, 12'd1, 8'h0F, 1'b1);
        tick();
        chk("b_done", 32'(done), 32'd1);

        // sew=64 avl=2: two full beats
        req_valid = 1'b1; req_sew = 2'd3; req_avl = 12'd2;
        tick();
        req_valid = 1'b0;
        chk_beat("c_b0", 1'b1, 12'd0, 8'hFF, 1'b0);
        tick();
        chk_beat("c_b1", 1'b1, 12'd1, 8'hFF, 1'b1);
        tick();
        chk("c_done", 32'(done), 32'd1);
        chk("c_err",  32'(err),  32'd0);

        // sew=16 avl=8 with stalled consumer; a request during RUN is ignored
        beat_ready = 1'b0;
        req_valid = 1'b1; req_sew = 2'd1; req_avl = 12'd8;
        tick();
        req_avl = 12'd100;
        for (int i = 0; i < 3; i++) begin
            chk_beat("d_stall", 1'b1, 12'd0, 8'hFF, 1'b0);
            chk("d_ready_stall", 32'(req_ready), 32'd0);
            tick();
        end
        chk_beat("d_stall_end", 1'b1, 12'd0, 8'hFF, 1'b0);
        req_valid = 1'b0; beat_ready = 1'b1;
        tick();
        chk_beat("d_b1", 1'b1, 12'd1, 8'hFF, 1'b1);
        tick();
        chk("d_done", 32'(done), 32'd1);
        chk("d_valid_end", 32'(beat_valid), 32'd0);

        // avl=0: accepted, no beats, done at N+1
        req_valid = 1'b1; req_sew = 2'd0; req_avl = 12'd0;
        tick();
        req_valid = 1'b0;
        chk("e_valid", 32'(beat_valid), 32'd0);
        chk("e_done",  32'(done),       32'd1);
        chk("e_ready", 32'(req_ready),  32'd1);
        chk("e_err",   32'(err),        32'd0);
        tick();
        chk("e_done_pulse", 32'(done), 32'd0);

        // 64-bit disabled instance: sew=64 rejected with err, no done
        req_valid2 = 1'b1; req_sew = 2'd3; req_avl = 12'd4;
        tick();
        req_valid2 = 1'b0;
        chk("f_err",   32'(err2),        32'd1);
        chk("f_done",  32'(done2),       32'd0);
        chk("f_valid", 32'(beat_valid2), 32'd0);
        chk("f_ready", 32'(req_ready2),  32'd1);
        tick();
        chk("f_err_pulse", 32'(err2), 32'd0);

        // sew=8 avl=64 (8 beats); flush together with off2 handshake
        req_valid = 1'b1; req_sew = 2'd0; req_avl = 12'd64;
        tick();
        req_valid = 1'b0;
        chk_beat("g_b0", 1'b1, 12'd0, 8'hFF, 1'b0);
        tick();
        tick();
        chk_beat("g_b2", 1'b1, 12'd2, 8'hFF, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("g_valid", 32'(beat_valid), 32'd0);
        chk("g_last",  32'(beat_last),  32'd0);
        chk("g_done",  32'(done),       32'd1);
        chk("g_ready", 32'(req_ready),  32'd1);
        tick();
        chk("g_no_b3",      32'(beat_valid), 32'd0);
        chk("g_done_pulse", 32'(done),       32'd0);

        // Flush while idle does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("h_idle_done",  32'(done),       32'd0);
        chk("h_idle_valid", 32'(beat_valid), 32'd0);

        // Reset in the middle of beat 4
        req_valid = 1'b1; req_sew = 2'd0; req_avl = 12'd64;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_beat("r_b4", 1'b1, 12'd4, 8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_beat("r_async", 1'b0, 12'd0, 8'h00, 1'b0);
        chk("r_ready", 32'(req_ready), 32'd1);
        chk("r_done",  32'(done),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_no_done", 32'(done), 32'd0);
        req_valid = 1'b1; req_sew = 2'd2; req_avl = 12'd3;
        tick();
        req_valid = 1'b0;
        chk_beat("r_new_b0", 1'b1, 12'd0, 8'hFF, 1'b0);
        tick();
        chk_beat("r_new_b1", 1'b1, 12'd1, 8'h0F, 1'b1);
        tick();
        chk("r_new_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vec_beat_sequencer
`default_nettype wire
